// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and programmable bit period
module mmio_uart_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input logic clk,
  input logic resetn,
  input logic sel,
  input logic wen,
  input logic ren,
  input logic [4:0] addr,
  input logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic [15:0] div, tmr;
  logic [1:0] st;
  logic [7:0] sh;
  logic [2:0] idx;
  logic ovf, full, empty, busy, wr, push_req, push, pop, clr, tend, unused;
  always_comb begin
    full = cnt == (AW+1)'(FIFO_DEPTH);
    empty = cnt == '0;
    busy = st != IDLE || !empty;
    wr = sel && wen;
    push_req = wr && addr[4:3] == 2'd0;
    push = push_req && !full;
    pop = st == IDLE && !empty;
    clr = wr && addr[4:3] == 2'd1 && wdata[3];
    tend = tmr == '0;
    txd = st == START ? 1'b0 : st == DATA ? sh[0] : 1'b1;
    rdata = !(sel && ren) ? 64'd0 :
            addr[4:3] == 2'd1 ? {60'd0, ovf, busy, empty, full} :
            addr[4:3] == 2'd2 ? {48'd0, div} : 64'd0;
    unused = ^{wdata[63:16], addr[2:0]};
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata[7:0];
  always_ff @(posedge clk) begin
    if (!resetn) begin
      st <= IDLE;
      cnt <= '0;
      rp <= '0;
      wp <= '0;
      ovf <= 1'b0;
      div <= DEFAULT_DIV;
      tmr <= '0;
      sh <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      ovf <= clr ? 1'b0 : (push_req && full) ? 1'b1 : ovf;
      div <= (wr && addr[4:3] == 2'd2) ? wdata[15:0] : div;
      case (st)
        IDLE: if (pop) begin
          sh <= mem[rp];
          st <= START;
          tmr <= div;
        end
        START: if (tend) begin
          st <= DATA;
          idx <= '0;
          tmr <= div;
        end else tmr <= tmr - 1'b1;
        DATA: if (tend) begin
          sh <= sh >> 1;
          idx <= idx + 1'b1;
          tmr <= div;
          st <= idx == 3'd7 ? STOP : DATA;
        end else tmr <= tmr - 1'b1;
        default: if (tend) begin
          st <= IDLE;
          tmr <= div;
        end else tmr <= tmr - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a frame-level model
module tb_mmio_uart_tx;
  localparam int DEPTH = 16;
  localparam logic [15:0] DEF = 16'd867;
  localparam logic [4:0] A_DATA = 5'h00, A_STAT = 5'h08, A_DIV = 5'h10;
  logic clk = 0, resetn = 0, sel = 0, wen = 0, ren = 0;
  logic [4:0] addr = 0;
  logic [63:0] wdata = 0, rdata;
  logic txd;
  int total = 0, passed = 0;
  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .resetn(resetn), .sel(sel), .wen(wen), .ren(ren),
    .addr(addr), .wdata(wdata), .rdata(rdata), .txd(txd)
  );
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic m_live = 0, m_ovf = 0, m_act = 0;
  logic [15:0] m_div = DEF;
  logic [9:0] m_frame = 0;
  int m_bi = 0, m_rem = 0;
  logic smp [1:80];
  logic [9:0] a5_line = 10'b1101001010;
  int lens [10] = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8};
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic model_edge();
    int n = q.size();
    logic push = sel && wen && addr[4:3] == 2'd0;
    if (!resetn) begin
      q.delete();
      m_ovf <= 0;
      m_div <= DEF;
      m_act <= 0;
      m_live <= 1;
    end else begin
      if (m_act) begin
        if (m_rem > 1) m_rem <= m_rem - 1;
        else if (m_bi == 9) m_act <= 0;
        else begin
          m_bi <= m_bi + 1;
          m_rem <= int'(m_div) + 1;
        end
      end else if (n != 0) begin
        m_frame <= {1'b1, q[0], 1'b0};
        void'(q.pop_front());
        m_act <= 1;
        m_bi <= 0;
        m_rem <= int'(m_div) + 1;
      end
      if (push && n < DEPTH) q.push_back(wdata[7:0]);
      if (sel && wen && addr[4:3] == 2'd2) m_div <= wdata[15:0];
      m_ovf <= (sel && wen && addr[4:3] == 2'd1 && wdata[3]) ? 1'b0 : (push && n == DEPTH) ? 1'b1 : m_ovf;
    end
  endtask
  always @(posedge clk) model_edge();
  function automatic logic [63:0] exp_rdata();
    if (!(sel && ren)) return 64'd0;
    if (addr[4:3] == 2'd1) return {60'd0, m_ovf, m_act || q.size() != 0, q.size() == 0, q.size() == DEPTH};
    if (addr[4:3] == 2'd2) return {48'd0, m_div};
    return 64'd0;
  endfunction
  always @(negedge clk)
    if (m_live) begin
      chk("txd", 64'(txd), 64'(m_act ? m_frame[m_bi] : 1'b1));
      chk("rdata", rdata, exp_rdata());
    end
  task automatic bus_wr(input logic [4:0] a, input logic [63:0] d);
    sel = 1; wen = 1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 0; wen = 0;
  endtask
  task automatic bus_rd(input logic [4:0] a, output logic [63:0] v);
    sel = 1; ren = 1; addr = a;
    @(negedge clk);
    v = rdata;
    @(posedge clk); #1;
    sel = 0; ren = 0;
  endtask
  task automatic wait_idle(input int budget);
    logic [63:0] s;
    int n = 0;
    do begin
      bus_rd(A_STAT, s);
      n++;
    end while (s[2] && n < budget);
    chk("drain_timeout", 64'(s[2]), 64'd0);
  endtask
  task automatic run(input int n, input int dk, input logic [4:0] da, input logic [63:0] dd);
    for (int k = 1; k <= n; k++) begin
      if (k == dk) begin sel = 1; wen = 1; addr = da; wdata = dd; end
      @(posedge clk); #1;
      sel = 0; wen = 0;
      smp[k] = txd;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] v;
    logic ok;
    int f1, r1, f2, pos, rr;
    logic [1:0] rg;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    bus_rd(A_STAT, v); chk("reset_status", v, 64'h2);
    bus_rd(A_DIV, v); chk("reset_div", v, 64'd867);
    chk("reset_txd", 64'(txd), 64'd1);
    bus_wr(A_DIV, 3);
    bus_wr(A_DATA, 64'hA5);
    run(40, 0, A_DATA, 0);
    ok = 1;
    for (int k = 1; k <= 40; k++) if (smp[k] !== a5_line[(k-1)/4]) ok = 0;
    chk("a5_frame", 64'(ok), 64'd1);
    bus_rd(A_STAT, v); chk("a5_busy_in_stop", v, 64'h6);
    bus_rd(A_STAT, v); chk("a5_idle_status", v, 64'h2);
    bus_wr(A_DIV, 50);
    bus_wr(A_DATA, 64'h11);
    bus_wr(A_DIV, 0);
    for (int i = 0; i < 17; i++) bus_wr(A_DATA, 64'($urandom));
    bus_rd(A_STAT, v); chk("ovf_full_status", v, 64'hD);
    bus_wr(A_STAT, 64'h8);
    bus_rd(A_STAT, v); chk("ovf_cleared", v, 64'h5);
    wait_idle(3000);
    bus_rd(A_STAT, v); chk("ovf_drained", v, 64'h2);
    bus_wr(A_DIV, 1);
    bus_wr(A_DATA, 64'h00);
    run(60, 1, A_DATA, 64'hFF);
    f1 = 0; r1 = 0; f2 = 0;
    for (int k = 1; k <= 60; k++) begin
      if (f1 == 0 && smp[k] == 0) f1 = k;
      else if (f1 != 0 && r1 == 0 && smp[k] == 1) r1 = k;
      else if (r1 != 0 && f2 == 0 && smp[k] == 0) f2 = k;
    end
    chk("b2b_first_start", 64'(f1), 64'd1);
    chk("b2b_start_spacing", 64'(f2 - f1), 64'd21);
    chk("b2b_idle_high_run", 64'(f2 - r1), 64'd3);
    wait_idle(500);
    bus_wr(A_DIV, 3);
    bus_wr(A_DATA, 64'h55);
    run(64, 14, A_DIV, 64'd7);
    ok = 1; pos = 1;
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < lens[b]; j++) begin
        if (smp[pos] !== logic'(b % 2)) ok = 0;
        pos++;
      end
    chk("div_midbit", 64'(ok), 64'd1);
    wait_idle(500);
    bus_wr(A_DIV, 3);
    bus_wr(A_DATA, 64'h3C);
    bus_wr(A_DATA, 64'($urandom));
    bus_wr(A_DATA, 64'($urandom));
    repeat (19) begin @(posedge clk); #1; end
    chk("bit4_before_reset", 64'(txd), 64'd1);
    resetn = 0;
    @(posedge clk); #1;
    resetn = 1;
    ok = 1;
    for (int k = 0; k < 60; k++) begin
      if (txd !== 1'b1) ok = 0;
      @(posedge clk); #1;
    end
    chk("abort_txd_high", 64'(ok), 64'd1);
    bus_rd(A_STAT, v); chk("abort_status", v, 64'h2);
    bus_rd(A_DIV, v); chk("abort_div", v, 64'd867);
    bus_wr(A_DIV, 2);
    for (int i = 0; i < 3000; i++) begin
      rr = $urandom_range(0, 9);
      rg = rr < 5 ? 2'd0 : rr < 7 ? 2'd1 : rr < 8 ? 2'd2 : 2'd3;
      sel = $urandom_range(0, 9) < 7;
      wen = $urandom_range(0, 1) == 1;
      ren = $urandom_range(0, 1) == 1;
      addr = {rg, 3'($urandom_range(0, 7))};
      wdata = {$urandom, $urandom};
      if (rg == 2'd2) wdata[15:0] = 16'($urandom_range(0, 3));
      resetn = $urandom_range(0, 999) != 0;
      @(posedge clk); #1;
    end
    sel = 0; wen = 0; ren = 0; resetn = 1;
    bus_wr(A_DIV, 0);
    wait_idle(3000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral on the core's data-memory bus, downstream of the MEM stage. The data memory mapper decodes the peripheral address window and forwards stores/loads here. Bytes stored to the DATA register queue in an internal FIFO and are serialised onto `txd` as 8N1 frames, LSB first, at a software-programmable bit period. Reads are combinational so MEM-stage load forwarding works unchanged.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: FIFO entries; power of two, at least 2.
- `DEFAULT_DIV`, 867: reset value of DIVISOR. Clocks per bit minus 1; 867 gives 115200 baud at 100 MHz.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `resetn`  in  1: **synchronous, active-low reset.**
- `sel`  in  1: peripheral window selected by the mapper this cycle.
- `wen`  in  1: store strobe; qualified by `sel`.
- `ren`  in  1: load strobe; qualified by `sel`.
- `addr`  in  5: byte offset within the window. `addr[4:3]` selects the register; `addr[2:0]` is ignored.
- `wdata`  in  64: store data; only the low bits used by each register are consumed.
- `rdata`  out  64: combinational load data. It is 0 unless `sel && ren`.
- `txd`  out  1: serial output; idles high.

## Operation
Register map, selected by `addr[4:3]`:
- 00 DATA
  - Write pushes `wdata[7:0]` into the FIFO.
  - If the FIFO is full, the byte is dropped and `overflow` is set.
  - Reads return 0.
- 01 STATUS
  - Read: bit0 = full, bit1 = empty, bit2 = busy (state != IDLE or FIFO not empty), bit3 = overflow. Upper bits are 0.
  - Write with `wdata[3]` = 1 clears `overflow`. Other bits are ignored.
- 10 DIVISOR
  - Read/write `wdata[15:0]`; upper bits read 0.
  - Bit period is DIVISOR+1 clocks. DIVISOR = 0 gives 1 clock per bit.
- 11 reserved: reads 0, writes ignored.

FIFO:
- Circular buffer with a count of 0..FIFO_DEPTH. Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- Full and empty are derived from the count.
- Push acceptance uses the pre-edge count. A push while full is dropped even if a pop happens on the same edge.
- Overflow: if a dropped push and a STATUS clear-write happen on the same edge, the clear wins. This cannot arise from a single bus access; it is defined for completeness.

Transmit FSM (states IDLE, START, DATA, STOP):
- IDLE: `txd` = 1. If the FIFO is not empty, pop the head into an 8-bit shift register and go to START on the same edge.
- START: `txd` = 0 for one bit period, then go to DATA with bit index 0.
- DATA: `txd` = shift[0] for one bit period. Then shift right and increment the index. After index 7, go to STOP.
- STOP: `txd` = 1 for one bit period, then go to IDLE.
- Bit timer:
  - Loads DIVISOR on every state entry and on every data-bit boundary.
  - Decrements each clock.
  - The bit period ends on the clock where the timer is 0.
- A DIVISOR write mid-bit does not alter the current bit. It applies from the next bit boundary.

## Timing
- Reset (`resetn` = 0 at an edge):
  - state = IDLE, `txd` = 1, FIFO count and both pointers = 0, overflow = 0, DIVISOR = DEFAULT_DIV, timer = 0.
  - `rdata` stays combinational (0 unless `sel && ren`).
- Reset asserted mid-frame aborts the frame: `txd` returns to 1 after that edge and FIFO contents are discarded.
- Write latency: a DATA store accepted at edge N gives count = 1 after N. The FSM pops at edge N+1, so `txd` falls after N+1.
- Frame length is 10·(DIVISOR+1) clocks from the START entry to the IDLE entry.
- Back-to-back bytes: IDLE lasts exactly one clock, so there are 10·(DIV+1)+1 clocks between start-bit falling edges.
- A pop and a push on the same edge leave the count unchanged; both pointers advance.
- STATUS reads reflect pre-edge state in the same cycle, consistent with the MEM-stage forwarding path.

## Test plan
- Reset, then read STATUS -> 0x2 (empty). Read DIVISOR -> 867. `txd` = 1 throughout.
- DIVISOR = 3, then store 0xA5 to DATA at edge N.
  - `txd` = 0 for clocks N+1..N+4, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks.
  - STATUS busy = 1 until the IDLE entry at N+41.
- DIVISOR = 0; store 17 bytes in consecutive cycles while `txd` is sampled.
  - STATUS full = 1 and overflow = 1 are observed before drain.
  - Exactly 16 frames are emitted, and the 17th byte never appears on `txd`.
  - A STATUS write of 0x8 clears overflow.
- DIVISOR = 1; store 0x00 then 0xFF.
  - Two frames separated by exactly one extra idle-high clock.
  - Start-bit falling edges are 21 clocks apart.
- DIVISOR = 3; store 0x55; in the middle of data bit 2, write DIVISOR = 7.
  - Bit 2 keeps 4 clocks; every later bit and the stop bit take 8 clocks.
- Store 0x3C with DIVISOR = 3, queue two more bytes, and pulse `resetn` low for one edge during data bit 4.
  - `txd` = 1 from that edge onward and no further frames are emitted.
  - STATUS reads 0x2 and DIVISOR reads 867.
